// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin write arbiter that shares one synchronous FIFO write
//            port between NREQ valid/ready requesters. A winner keeps the
//            grant for a burst of up to MAXBURST words. The registered write
//            in flight is counted against the FIFO fill level, so the FIFO is
//            never overflowed.
// Ports    : i_clk, i_rst_n           clock, async active-low reset
//            i_req_valid/i_req_data   per-requester valid and packed data
//            o_req_ready              per-requester ready (at most one high)
//            i_fifo_full/i_fifo_fill  FIFO status
//            o_fifo_wr/o_fifo_data    registered FIFO write
//            o_grant_id               current or last granted requester
//            o_stall_cnt              saturating stall counter (optional)
//            o_busy                   high while a burst is in progress
// Options  : define FIFO_ARB_STALL_CNT_EN to add o_stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int BW       = 8,
    parameter int LGFLEN   = 4,
    parameter int MAXBURST = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NREQ-1:0]           i_req_valid,
    input  logic [NREQ*BW-1:0]        i_req_data,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic                      i_fifo_full,
    input  logic [LGFLEN:0]           i_fifo_fill,
    output logic                      o_fifo_wr,
    output logic [BW-1:0]             o_fifo_data,
    output logic [$clog2(NREQ)-1:0]   o_grant_id,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [15:0]               o_stall_cnt,
`endif
    output logic                      o_busy
);

    localparam int                  c_gw        = $clog2(NREQ);
    localparam logic [0:0]          c_idle      = 1'b0;
    localparam logic [0:0]          c_burst     = 1'b1;
    localparam logic [LGFLEN+1:0]   c_depth     = {1'b0, 1'b1, {LGFLEN{1'b0}}};
    localparam logic [c_gw-1:0]     c_last_init = c_gw'(NREQ - 1);
    localparam logic [3:0]          c_cnt_last  = 4'(MAXBURST - 1);

    logic [0:0]        r_state;
    logic [c_gw-1:0]   r_last_grant;
    logic [3:0]        r_count;

    logic [LGFLEN+1:0] w_sum;
    logic              w_space_ok;
    logic              w_gvalid;
    logic [BW-1:0]     w_gdata;
    logic              w_hs;
    logic              w_any;
    logic [c_gw-1:0]   w_pick;

    // The write registered last cycle lands in the FIFO this edge, so it
    // already occupies an entry even though i_fifo_fill does not show it.
    assign w_sum      = {1'b0, i_fifo_fill} + {{(LGFLEN+1){1'b0}}, o_fifo_wr};
    assign w_space_ok = !i_fifo_full && (w_sum < c_depth);

    assign w_gvalid = i_req_valid[o_grant_id];
    assign w_gdata  = i_req_data[int'(o_grant_id)*BW +: BW];
    assign w_hs     = (r_state == c_burst) && w_gvalid && w_space_ok;
    assign o_busy   = (r_state == c_burst);

    // Round-robin pick: first valid requester after the last grant, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last_grant;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_any && i_req_valid[(int'(r_last_grant) + i) % NREQ]) begin
                w_any  = 1'b1;
                w_pick = c_gw'((int'(r_last_grant) + i) % NREQ);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if ((r_state == c_burst) && w_space_ok) begin
            o_req_ready[o_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_idle;
            r_last_grant <= c_last_init;
            r_count      <= '0;
            o_grant_id   <= '0;
            o_fifo_wr    <= 1'b0;
            o_fifo_data  <= '0;
        end else begin
            o_fifo_wr <= w_hs;
            if (w_hs) begin
                o_fifo_data <= w_gdata;
            end
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        o_grant_id   <= w_pick;
                        r_last_grant <= w_pick;
                        r_count      <= '0;
                        r_state      <= c_burst;
                    end
                end
                default: begin
                    // A dropped valid ends the burst; a full FIFO only stalls it.
                    if (!w_gvalid) begin
                        r_state <= c_idle;
                    end else if (w_hs) begin
                        r_count <= r_count + 4'd1;
                        if (r_count == c_cnt_last) begin
                            r_state <= c_idle;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == c_burst) && w_gvalid && !w_space_ok
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter with a counting FIFO
//            model, requester word sources and a write-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic [4:0]  fifo_fill;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .BW(8), .LGFLEN(4), .MAXBURST(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .i_fifo_full (fifo_full),
        .i_fifo_fill (fifo_fill),
        .o_fifo_wr   (fifo_wr),
        .o_fifo_data (fifo_data),
        .o_grant_id  (grant_id),
`ifdef FIFO_ARB_STALL_CNT_EN
        .o_stall_cnt (stall_cnt),
`endif
        .o_busy      (busy)
    );

    // 16-entry FIFO occupancy model
    logic [4:0] fcnt;
    logic       tb_rd;
    logic       tb_load;

    always @(posedge clk) begin
        if (!rst_n)       fcnt <= 5'd0;
        else if (tb_load) fcnt <= 5'd15;
        else              fcnt <= fcnt + {4'b0, fifo_wr} - {4'b0, (tb_rd && fcnt != 5'd0)};
    end
    assign fifo_fill = fcnt;
    assign fifo_full = (fcnt == 5'd16);

    int         nchk = 0;
    int         nerr = 0;
    int         cyc;
    int         rem [4];
    logic [7:0] nxt [4];
    logic [7:0] sb [$];
    int         hs_log [$];
    int         hs_cyc [$];
    logic [3:0] smp_ready;

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_valid[k]       = (rem[k] > 0);
            req_data[k*8 +: 8] = nxt[k];
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tb_rd   = 1'b0;
        tb_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0;
            nxt[k] = 8'h00;
        end
        drive();
        sb.delete();
        hs_log.delete();
        hs_cyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock: observe handshakes before the edge, check the write after it.
    task automatic step(input bit rd);
        int hs_k;
        hs_k = -1;
        #1;
        tb_rd     = rd;
        smp_ready = req_ready;
        nchk++;
        if ($countones(req_ready) > 1) begin
            nerr++;
            $display("FAIL ready_onehot: got %b required at most one bit", req_ready);
        end
        nchk++;
        if (fifo_wr && fifo_full) begin
            nerr++;
            $display("FAIL overflow: got write while full, required no write");
        end
        for (int k = 0; k < 4; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                sb.push_back(nxt[k]);
                hs_k = k;
            end
        end
        if (hs_k >= 0) begin
            hs_log.push_back(hs_k);
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        nchk++;
        if (fifo_wr !== (hs_k >= 0)) begin
            nerr++;
            $display("FAIL wr_latency: got o_fifo_wr=%b required %b", fifo_wr, (hs_k >= 0));
        end
        if (fifo_wr === 1'b1 && sb.size() > 0) begin
            logic [7:0] exp_d;
            exp_d = sb.pop_front();
            nchk++;
            if (fifo_data !== exp_d) begin
                nerr++;
                $display("FAIL wr_data: got %h required %h", fifo_data, exp_d);
            end
        end
        if (hs_k >= 0) begin
            rem[hs_k]--;
            nxt[hs_k]++;
        end
        @(negedge clk);
        drive();
    endtask

    task automatic run(input int budget, input bit rd);
        int n;
        n = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3] > 0 || sb.size() > 0) && n < budget) begin
            step(rd);
            n++;
        end
        nchk++;
        if (n >= budget) begin
            nerr++;
            $display("FAIL timeout: got %0d words outstanding required 0", rem[0] + rem[1] + rem[2] + rem[3]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0;
            nxt[k] = 8'h00;
        end
        tb_rd = 1'b0; tb_load = 1'b0;
        drive();
        repeat (3) @(negedge clk);
        nchk += 5;
        if (fifo_wr !== 1'b0)    begin nerr++; $display("FAIL rst_wr: got %b required 0", fifo_wr); end
        if (fifo_data !== 8'h00) begin nerr++; $display("FAIL rst_data: got %h required 00", fifo_data); end
        if (req_ready !== 4'h0)  begin nerr++; $display("FAIL rst_ready: got %b required 0000", req_ready); end
        if (busy !== 1'b0)       begin nerr++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (grant_id !== 2'd0)   begin nerr++; $display("FAIL rst_grant: got %0d required 0", grant_id); end
`ifdef FIFO_ARB_STALL_CNT_EN
        nchk++;
        if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL rst_stall: got %0d required 0", stall_cnt); end
`endif
    endtask

    task automatic test_single();
        int exp_c [6] = '{1, 2, 3, 4, 6, 7};
        do_reset();
        rem[0] = 6; nxt[0] = 8'hA0;
        drive();
        run(40, 1'b0);
        step(1'b0);
        step(1'b0);
        nchk++;
        if (hs_cyc.size() != 6) begin
            nerr++; $display("FAIL single_count: got %0d required 6", hs_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                nchk++;
                if (hs_cyc[i] != exp_c[i]) begin
                    nerr++; $display("FAIL single_cycle[%0d]: got %0d required %0d", i, hs_cyc[i], exp_c[i]);
                end
            end
        end
        nchk++;
        if (fcnt !== 5'd6) begin nerr++; $display("FAIL single_fill: got %0d required 6", fcnt); end
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        do_reset();
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        nxt[0] = 8'h00; nxt[1] = 8'h10; nxt[2] = 8'h20; nxt[3] = 8'h30;
        drive();
        run(200, 1'b1);
        nchk++;
        if (hs_log.size() != 20) begin
            nerr++; $display("FAIL rr_count: got %0d required 20", hs_log.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                nchk++;
                if (hs_log[i] != exp_g[i/4]) begin
                    nerr++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, hs_log[i], exp_g[i/4]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        tb_load = 1'b1;
        @(posedge clk);
        #1 tb_load = 1'b0;
        @(negedge clk);
        rem[2] = 3; nxt[2] = 8'hC0;
        drive();
        cyc = 0;
        step(1'b0);
        step(1'b0);
        nchk++;
        if (smp_ready !== 4'b0100) begin nerr++; $display("FAIL stall_first: got %b required 0100", smp_ready); end
        for (int i = 0; i < 6; i++) begin
            step(i == 5);
            nchk++;
            if (smp_ready !== 4'b0000) begin nerr++; $display("FAIL stall_low[%0d]: got %b required 0000", i, smp_ready); end
        end
        step(1'b0);
        nchk++;
        if (smp_ready !== 4'b0100) begin nerr++; $display("FAIL stall_resume: got %b required 0100", smp_ready); end
`ifdef FIFO_ARB_STALL_CNT_EN
        nchk++;
        if (stall_cnt !== 16'd6) begin nerr++; $display("FAIL stall_cnt: got %0d required 6", stall_cnt); end
`endif
        step(1'b0);
        nchk++;
        if (smp_ready !== 4'b0000) begin nerr++; $display("FAIL stall_again: got %b required 0000", smp_ready); end
        nchk++;
        if (hs_log.size() != 2) begin nerr++; $display("FAIL stall_words: got %0d required 2", hs_log.size()); end
    endtask

    task automatic test_early_release();
        int exp_g [4] = '{1, 1, 2, 1};
        do_reset();
        rem[1] = 2; nxt[1] = 8'h50;
        rem[2] = 1; nxt[2] = 8'h60;
        drive();
        repeat (4) step(1'b0);
        rem[1] = 1;
        drive();
        run(40, 1'b0);
        nchk++;
        if (hs_log.size() != 4) begin
            nerr++; $display("FAIL early_count: got %0d required 4", hs_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nchk++;
                if (hs_log[i] != exp_g[i]) begin
                    nerr++; $display("FAIL early_order[%0d]: got %0d required %0d", i, hs_log[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rem[1] = 5; nxt[1] = 8'h70;
        drive();
        repeat (3) step(1'b0);
        nchk++;
        if (fifo_wr !== 1'b1 || grant_id !== 2'd1) begin
            nerr++; $display("FAIL arst_pre: got wr=%b grant=%0d required wr=1 grant=1", fifo_wr, grant_id);
        end
        #2 rst_n = 1'b0;
        #1;
        nchk += 5;
        if (fifo_wr !== 1'b0)    begin nerr++; $display("FAIL arst_wr: got %b required 0", fifo_wr); end
        if (fifo_data !== 8'h00) begin nerr++; $display("FAIL arst_data: got %h required 00", fifo_data); end
        if (req_ready !== 4'h0)  begin nerr++; $display("FAIL arst_ready: got %b required 0000", req_ready); end
        if (busy !== 1'b0)       begin nerr++; $display("FAIL arst_busy: got %b required 0", busy); end
        if (grant_id !== 2'd0)   begin nerr++; $display("FAIL arst_grant: got %0d required 0", grant_id); end
        for (int k = 0; k < 4; k++) rem[k] = 0;
        rem[0] = 1; nxt[0] = 8'h80;
        rem[2] = 1; nxt[2] = 8'h90;
        drive();
        sb.delete();
        hs_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(40, 1'b0);
        nchk++;
        if (hs_log.size() < 1 || hs_log[0] != 0) begin
            nerr++; $display("FAIL arst_first_grant: got %0d required 0", (hs_log.size() > 0) ? hs_log[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
